brew_ctrl: RTL and testbench

BREW_CTRL -- requirements
Module: brew_ctrl

---
 rtl/brew_pkg.sv | 33 +++
 rtl/brew_if.sv | 29 ++
 rtl/brew_timer.sv | 38 +++
 rtl/brew_ctrl.sv | 125 ++++++++++++
 tb/tb_brew_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/brew_pkg.sv
// Shared types for the brew controller: state encoding, recipe encoding
// and small elaboration-time helpers.
package brew_pkg;

  // State encodings are visible on STATE_CODE, so the values are fixed.
  typedef enum logic [2:0] {
    ST_STANDBY     = 3'd0,
    ST_WORKING     = 3'd1,
    ST_POUR_COFFEE = 3'd2,
    ST_POUR_MILK   = 3'd3,
    ST_NEED_MILK   = 3'd4,
    ST_DONE        = 3'd5,
    ST_ENJOY       = 3'd6
  } state_e;

  // Recipe select as presented on MODE.
  typedef enum logic [1:0] {
    RCP_NONE      = 2'b00,
    RCP_BLACK     = 2'b01,
    RCP_MILK_ONLY = 2'b10,
    RCP_LATTE     = 2'b11
  } recipe_e;

  // Recipes that draw from the milk supply.
  function automatic logic recipe_needs_milk(input recipe_e r);
    return (r == RCP_MILK_ONLY) || (r == RCP_LATTE);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/brew_if.sv
// Front-panel / actuator bundle of the brew controller. The controller
// takes the slave side; whoever drives the panel takes the master side.
interface brew_if #(
  parameter int CUP_W = 8
);

  logic             START;
  logic [1:0]       MODE;
  logic             MILK_OK;
  logic             CANCEL;
  logic [2:0]       STATE_CODE;
  logic             HEATER;
  logic             COFFEE_VALVE;
  logic             MILK_VALVE;
  logic             BUSY;
  logic             DONE_P;
  logic [CUP_W-1:0] CUPS;

  modport master (
    output START, MODE, MILK_OK, CANCEL,
    input  STATE_CODE, HEATER, COFFEE_VALVE, MILK_VALVE, BUSY, DONE_P, CUPS
  );

  modport slave (
    input  START, MODE, MILK_OK, CANCEL,
    output STATE_CODE, HEATER, COFFEE_VALVE, MILK_VALVE, BUSY, DONE_P, CUPS
  );

endinterface

// File: rtl/brew_timer.sv
// Loadable down-counter used to time each brewing phase. It loads on the
// edge that enters a timed state and counts down to zero, then holds.
module brew_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/brew_ctrl.sv
// Drink sequencer: waits for a request in STANDBY, optionally waits for
// milk, heats, pours coffee and/or milk, then signals completion and
// counts the cup. CANCEL aborts any active phase back to STANDBY.
module brew_ctrl #(
  parameter int BREW_CYC   = 8,
  parameter int COFFEE_CYC = 6,
  parameter int MILK_CYC   = 4,
  parameter int DONE_CYC   = 4,
  parameter int CUP_W      = 8
) (
  input logic   CLK,
  input logic   R_N,
  brew_if.slave bus
);

  import brew_pkg::*;

  // The timer holds duration-1, so the longest phase sets the width.
  localparam int MAX_CYC = max_of(max_of(BREW_CYC, COFFEE_CYC), max_of(MILK_CYC, DONE_CYC));
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e             state_q, state_d;
  recipe_e            recipe_q, recipe_d;
  logic [CUP_W-1:0]   cups_q, cups_d;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_zero;

  brew_timer #(.W(TMR_W)) u_timer (
    .clk   (CLK),
    .rst_n (R_N),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Next-state, recipe capture and timer load on entry to a timed phase.
  always_comb begin
    state_d   = state_q;
    recipe_d  = recipe_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    case (state_q)
      ST_STANDBY: begin
        if (bus.START && (bus.MODE != RCP_NONE)) begin
          recipe_d = recipe_e'(bus.MODE);
          if (!recipe_needs_milk(recipe_e'(bus.MODE)) || bus.MILK_OK) begin
            state_d = ST_WORKING;
          end else begin
            state_d = ST_NEED_MILK;
          end
        end
      end
      ST_NEED_MILK: begin
        if (bus.CANCEL)       state_d = ST_STANDBY;
        else if (bus.MILK_OK) state_d = ST_WORKING;
      end
      ST_WORKING: begin
        if (bus.CANCEL) state_d = ST_STANDBY;
        else if (tmr_zero) begin
          state_d = (recipe_q == RCP_MILK_ONLY) ? ST_POUR_MILK : ST_POUR_COFFEE;
        end
      end
      ST_POUR_COFFEE: begin
        if (bus.CANCEL) state_d = ST_STANDBY;
        else if (tmr_zero) begin
          state_d = (recipe_q == RCP_LATTE) ? ST_POUR_MILK : ST_DONE;
        end
      end
      ST_POUR_MILK: begin
        if (bus.CANCEL)    state_d = ST_STANDBY;
        else if (tmr_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.CANCEL)    state_d = ST_STANDBY;
        else if (tmr_zero) state_d = ST_ENJOY;
      end
      ST_ENJOY: state_d = ST_STANDBY;
      default:  state_d = ST_STANDBY;
    endcase

    // A phase lasting N cycles loads N-1 and leaves on the cycle it reads 0.
    if (state_d != state_q) begin
      case (state_d)
        ST_WORKING:     begin tmr_load = 1'b1; tmr_value = TMR_W'(BREW_CYC - 1);   end
        ST_POUR_COFFEE: begin tmr_load = 1'b1; tmr_value = TMR_W'(COFFEE_CYC - 1); end
        ST_POUR_MILK:   begin tmr_load = 1'b1; tmr_value = TMR_W'(MILK_CYC - 1);   end
        ST_DONE:        begin tmr_load = 1'b1; tmr_value = TMR_W'(DONE_CYC - 1);   end
        default:        ;
      endcase
    end
  end

  // Cup counter: count on entry to ENJOY, saturating at all-ones.
  always_comb begin
    cups_d = cups_q;
    if ((state_d == ST_ENJOY) && (state_q != ST_ENJOY) && (cups_q != '1)) begin
      cups_d = cups_q + 1'b1;
    end
  end

  // State, recipe and cup registers.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_q  <= ST_STANDBY;
      recipe_q <= RCP_NONE;
      cups_q   <= '0;
    end else begin
      state_q  <= state_d;
      recipe_q <= recipe_d;
      cups_q   <= cups_d;
    end
  end

  // Moore outputs decoded from the current state only.
  assign bus.STATE_CODE   = state_q;
  assign bus.HEATER       = (state_q == ST_WORKING);
  assign bus.COFFEE_VALVE = (state_q == ST_POUR_COFFEE);
  assign bus.MILK_VALVE   = (state_q == ST_POUR_MILK);
  assign bus.DONE_P       = (state_q == ST_ENJOY);
  assign bus.BUSY         = (state_q != ST_STANDBY);
  assign bus.CUPS         = cups_q;

endmodule

// File: tb/tb_brew_ctrl.sv
// Bench for brew_ctrl: a per-cycle vector table for whole drinks and
// cancels, plus hand-written sequences for reset and cup saturation.
module tb_brew_ctrl;

  import brew_pkg::*;

  localparam int BREW   = 4;
  localparam int COFFEE = 3;
  localparam int MILK   = 2;
  localparam int DONE   = 2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start   = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic       milk_ok = 1'b0;
  logic       cancel  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  brew_if #(.CUP_W(8)) bus_a ();
  brew_if #(.CUP_W(2)) bus_b ();

  assign bus_a.START   = start;
  assign bus_a.MODE    = mode;
  assign bus_a.MILK_OK = milk_ok;
  assign bus_a.CANCEL  = cancel;
  assign bus_b.START   = start;
  assign bus_b.MODE    = mode;
  assign bus_b.MILK_OK = milk_ok;
  assign bus_b.CANCEL  = cancel;

  brew_ctrl #(
    .BREW_CYC(BREW), .COFFEE_CYC(COFFEE), .MILK_CYC(MILK), .DONE_CYC(DONE), .CUP_W(8)
  ) dut_a (
    .CLK (clk),
    .R_N (rst_n),
    .bus (bus_a.slave)
  );

  brew_ctrl #(
    .BREW_CYC(BREW), .COFFEE_CYC(COFFEE), .MILK_CYC(MILK), .DONE_CYC(DONE), .CUP_W(2)
  ) dut_b (
    .CLK (clk),
    .R_N (rst_n),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       milk_ok;
    logic       cancel;
    logic [2:0] exp_state;
    logic [7:0] exp_cups;
  } vec_t;

  vec_t vecs[$];
  int   tbl_cups = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Append reps cycles with the same inputs and expected post-edge state.
  task automatic add(input logic s, input logic [1:0] m, input logic mk, input logic c,
                     input logic [2:0] st, input int reps);
    for (int i = 0; i < reps; i++) begin
      vec_t v;
      v.start   = (i == 0) ? s : 1'b0;
      v.mode    = m;
      v.milk_ok = mk;
      v.cancel  = c;
      v.exp_state = st;
      if (st == 3'd6) tbl_cups++;
      v.exp_cups = 8'(tbl_cups);
      vecs.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc, input string nm);
    int n = 0;
    while (bus_a.STATE_CODE !== st && n < max_cyc) begin
      step();
      n++;
    end
    check(nm, 32'(bus_a.STATE_CODE), 32'(st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Idle: START with MODE=00 ignored; CANCEL ignored in STANDBY.
    add(1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 2);
    add(1'b0, 2'b01, 1'b1, 1'b1, 3'd0, 1);
    // Black coffee, no milk needed even with MILK_OK=0.
    add(1'b1, 2'b01, 1'b0, 1'b0, 3'd1, 1);
    add(1'b0, 2'b01, 1'b0, 1'b0, 3'd1, 3);
    add(1'b0, 2'b01, 1'b0, 1'b0, 3'd2, 3);
    add(1'b0, 2'b01, 1'b0, 1'b0, 3'd5, 2);
    add(1'b0, 2'b01, 1'b0, 1'b0, 3'd6, 1);
    add(1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 1);
    // Coffee with milk, waits five cycles for milk.
    add(1'b1, 2'b11, 1'b0, 1'b0, 3'd4, 1);
    add(1'b0, 2'b11, 1'b0, 1'b0, 3'd4, 4);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd2, 3);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd3, 2);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd5, 2);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd6, 1);
    add(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 1);
    // Hot milk only.
    add(1'b1, 2'b10, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd3, 2);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd5, 2);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd6, 1);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd0, 1);
    // Cancel in the 2nd cycle of POUR_COFFEE.
    add(1'b1, 2'b01, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 2);
    add(1'b0, 2'b01, 1'b1, 1'b1, 3'd0, 1);
    // A following black coffee runs normally.
    add(1'b1, 2'b01, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 3);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd5, 2);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd6, 1);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd0, 1);
    // Cancel beats timer expiry in the last WORKING cycle.
    add(1'b1, 2'b01, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b01, 1'b1, 1'b1, 3'd0, 1);
    // Cancel beats MILK_OK in NEED_MILK.
    add(1'b1, 2'b11, 1'b0, 1'b0, 3'd4, 1);
    add(1'b0, 2'b11, 1'b1, 1'b1, 3'd0, 1);
    // Cancel in POUR_MILK.
    add(1'b1, 2'b10, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b10, 1'b1, 1'b0, 3'd3, 1);
    add(1'b0, 2'b10, 1'b1, 1'b1, 3'd0, 1);
    // Cancel in the last DONE cycle does not count a cup.
    add(1'b1, 2'b01, 1'b1, 1'b0, 3'd1, 1);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd1, 3);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 3);
    add(1'b0, 2'b01, 1'b1, 1'b0, 3'd5, 2);
    add(1'b0, 2'b01, 1'b1, 1'b1, 3'd0, 1);

    // Reset is asynchronous: observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_async.state", 32'(bus_a.STATE_CODE), 32'd0);
    check("reset_async.busy",  32'(bus_a.BUSY),       32'd0);
    check("reset_async.cups",  32'(bus_a.CUPS),       32'd0);
    check("reset_async.act",   32'({bus_a.HEATER, bus_a.COFFEE_VALVE, bus_a.MILK_VALVE, bus_a.DONE_P}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      start   = vecs[i].start;
      mode    = vecs[i].mode;
      milk_ok = vecs[i].milk_ok;
      cancel  = vecs[i].cancel;
      step();
      check($sformatf("vec%0d.state", i),  32'(bus_a.STATE_CODE),   32'(vecs[i].exp_state));
      check($sformatf("vec%0d.heater", i), 32'(bus_a.HEATER),       32'(vecs[i].exp_state == 3'd1));
      check($sformatf("vec%0d.coffee", i), 32'(bus_a.COFFEE_VALVE), 32'(vecs[i].exp_state == 3'd2));
      check($sformatf("vec%0d.milk", i),   32'(bus_a.MILK_VALVE),   32'(vecs[i].exp_state == 3'd3));
      check($sformatf("vec%0d.busy", i),   32'(bus_a.BUSY),         32'(vecs[i].exp_state != 3'd0));
      check($sformatf("vec%0d.done_p", i), 32'(bus_a.DONE_P),       32'(vecs[i].exp_state == 3'd6));
      check($sformatf("vec%0d.cups", i),   32'(bus_a.CUPS),         32'(vecs[i].exp_cups));
    end
    start  = 1'b0;
    cancel = 1'b0;

    // Reset pulsed during POUR_MILK: immediate STANDBY and CUPS cleared.
    start = 1'b1; mode = 2'b11; milk_ok = 1'b1;
    step();
    start = 1'b0;
    wait_state(3'd3, 20, "rst_mid.reach_pour_milk");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.state",  32'(bus_a.STATE_CODE), 32'd0);
    check("rst_mid.milk",   32'(bus_a.MILK_VALVE), 32'd0);
    check("rst_mid.busy",   32'(bus_a.BUSY),       32'd0);
    check("rst_mid.cups_a", 32'(bus_a.CUPS),       32'd0);
    check("rst_mid.cups_b", 32'(bus_b.CUPS),       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_mid.after", 32'(bus_a.STATE_CODE), 32'd0);

    // Five black coffees: 2-bit counter saturates, 8-bit keeps counting.
    for (int d = 0; d < 5; d++) begin
      start = 1'b1; mode = 2'b01;
      step();
      start = 1'b0;
      wait_state(3'd6, 20, $sformatf("sat%0d.reach_enjoy", d));
      check($sformatf("sat%0d.cups_b", d), 32'(bus_b.CUPS),   32'(sat_exp[d]));
      check($sformatf("sat%0d.cups_a", d), 32'(bus_a.CUPS),   32'(d + 1));
      check($sformatf("sat%0d.done_p", d), 32'(bus_b.DONE_P), 32'd1);
      step();
      check($sformatf("sat%0d.standby", d), 32'(bus_b.STATE_CODE), 32'd0);
      check($sformatf("sat%0d.done_off", d), 32'(bus_b.DONE_P),    32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
